// File: rtl/max_tracker_pipe.sv
// max_tracker_pipe: pipelined running-maximum tracker for the local-alignment
// scoring array. A registered binary comparator tree reduces LANES masked
// cells per beat to one candidate. The candidate is folded into a running
// maximum per frame, and the frame peak is delivered over a valid/ready
// result handshake.
module max_tracker_pipe #(
  parameter int LANES          = 64,
  parameter int SCORE_WIDTH    = 10,
  parameter int ROW_BITS_WIDTH = 7,
  parameter int COL_BITS_WIDTH = 7,
  parameter int BEAT_WIDTH     = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clr,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                in_last,
  input  logic [LANES-1:0]                    in_lane_en,
  input  logic [LANES*SCORE_WIDTH-1:0]        in_score,
  input  logic [LANES*ROW_BITS_WIDTH-1:0]     in_row,
  input  logic [LANES*COL_BITS_WIDTH-1:0]     in_col,
  input  logic [SCORE_WIDTH-1:0]              threshold,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [SCORE_WIDTH-1:0]              res_score,
  output logic [ROW_BITS_WIDTH-1:0]           res_row,
  output logic [COL_BITS_WIDTH-1:0]           res_col,
  output logic                                res_found,
  output logic                                res_above,
  output logic [BEAT_WIDTH-1:0]               res_beats
);

  // Number of tree levels after the leaf register; the root sits at level D.
  localparam int D   = $clog2(LANES);
  localparam int DCW = $clog2(D + 1);

  typedef struct packed {
    logic                      found;
    logic [SCORE_WIDTH-1:0]    score;
    logic [ROW_BITS_WIDTH-1:0] row;
    logic [COL_BITS_WIDTH-1:0] col;
  } node_t;

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

  // Heap layout: leaves at LANES..2*LANES-1, node i merges 2i (left, lower
  // lane) with 2i+1, root at index 1.
  node_t            tree_p [1:2*LANES-1];
  logic [D:0]       vld_p;
  logic [D:0]       last_p;

  state_t           state;
  logic [DCW-1:0]   drain_cnt;
  logic [BEAT_WIDTH-1:0] beats;
  node_t            run;
  node_t            final_node;
  logic             accept;

  // Right operand replaces the left only when it is found and either the
  // left is not found or the right is strictly larger; ties keep the left.
  function automatic node_t merge_node(input node_t a, input node_t b);
    if (b.found && (!a.found || (b.score > a.score)))
      return b;
    return a;
  endfunction

  // Disabled lanes enter as all-zero so an empty frame reports zeros.
  function automatic node_t make_leaf(input logic en,
                                      input logic [SCORE_WIDTH-1:0] s,
                                      input logic [ROW_BITS_WIDTH-1:0] r,
                                      input logic [COL_BITS_WIDTH-1:0] c);
    node_t n;
    n       = '0;
    n.found = en;
    if (en) begin
      n.score = s;
      n.row   = r;
      n.col   = c;
    end
    return n;
  endfunction

  function automatic logic [BEAT_WIDTH-1:0] sat_inc(input logic [BEAT_WIDTH-1:0] v);
    if (&v)
      return v;
    return v + 1'b1;
  endfunction

  assign accept     = in_valid && in_ready;
  assign final_node = merge_node(run, tree_p[1]);

  // Comparator tree: leaf capture plus one registered merge per level, with
  // valid/last bits shifting alongside; beats never stall inside the tree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p  <= '0;
      last_p <= '0;
      for (int i = 1; i < 2*LANES; i++)
        tree_p[i] <= '0;
    end else begin
      if (clr) begin
        vld_p  <= '0;
        last_p <= '0;
      end else begin
        vld_p  <= {vld_p[D-1:0], accept};
        last_p <= {last_p[D-1:0], accept && in_last};
      end
      for (int i = 0; i < LANES; i++)
        tree_p[LANES+i] <= make_leaf(in_lane_en[i],
                                     in_score[i*SCORE_WIDTH +: SCORE_WIDTH],
                                     in_row[i*ROW_BITS_WIDTH +: ROW_BITS_WIDTH],
                                     in_col[i*COL_BITS_WIDTH +: COL_BITS_WIDTH]);
      for (int i = 1; i < LANES; i++)
        tree_p[i] <= merge_node(tree_p[2*i], tree_p[2*i+1]);
    end
  end

  // Frame control FSM with running maximum, beat counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      in_ready  <= 1'b1;
      res_valid <= 1'b0;
      drain_cnt <= '0;
      beats     <= '0;
      run       <= '0;
      res_score <= '0;
      res_row   <= '0;
      res_col   <= '0;
      res_found <= 1'b0;
      res_above <= 1'b0;
      res_beats <= '0;
    end else if (clr) begin
      state     <= ACCUM;
      in_ready  <= 1'b1;
      res_valid <= 1'b0;
      drain_cnt <= '0;
      beats     <= '0;
      run       <= '0;
      res_score <= '0;
      res_row   <= '0;
      res_col   <= '0;
      res_found <= 1'b0;
      res_above <= 1'b0;
      res_beats <= '0;
    end else begin
      if (accept)
        beats <= sat_inc(beats);
      if (vld_p[D])
        run <= merge_node(run, tree_p[1]);
      case (state)
        ACCUM: begin
          if (accept && in_last) begin
            state     <= DRAIN;
            in_ready  <= 1'b0;
            drain_cnt <= DCW'(D);
          end
        end
        DRAIN: begin
          if (drain_cnt != '0) begin
            drain_cnt <= drain_cnt - 1'b1;
          end else if (last_p[D]) begin
            // Root now holds the last beat: fold it in and publish.
            res_score <= final_node.score;
            res_row   <= final_node.row;
            res_col   <= final_node.col;
            res_found <= final_node.found;
            res_above <= final_node.found && (final_node.score >= threshold);
            res_beats <= beats;
            res_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (res_ready) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            res_valid <= 1'b0;
            run       <= '0;
            beats     <= '0;
          end
        end
        default: begin
          state    <= ACCUM;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max_tracker_pipe.sv
// Testbench for max_tracker_pipe (LANES=4, BEAT_WIDTH=4): directed frames
// plus randomized frames checked against a scan-order reference model.
module tb_max_tracker_pipe;

  localparam int L    = 4;
  localparam int SW   = 10;
  localparam int RW   = 7;
  localparam int CW   = 7;
  localparam int BW   = 4;
  localparam int D    = 2;
  localparam int MAXB = 24;

  logic              clk = 1'b0;
  logic              rst_n, clr, in_valid, in_ready, in_last;
  logic [L-1:0]      in_lane_en;
  logic [L*SW-1:0]   in_score;
  logic [L*RW-1:0]   in_row;
  logic [L*CW-1:0]   in_col;
  logic [SW-1:0]     threshold;
  logic              res_valid, res_ready, res_found, res_above;
  logic [SW-1:0]     res_score;
  logic [RW-1:0]     res_row;
  logic [CW-1:0]     res_col;
  logic [BW-1:0]     res_beats;

  int unsigned b_score [MAXB][L];
  int unsigned b_row   [MAXB][L];
  int unsigned b_col   [MAXB][L];
  bit          b_en    [MAXB][L];
  int          nb;
  int          cur_thr;

  int unsigned e_score, e_row, e_col, e_beats;
  bit          e_found, e_above;

  int n_vec = 0;
  int n_err = 0;

  max_tracker_pipe #(
    .LANES(L), .SCORE_WIDTH(SW), .ROW_BITS_WIDTH(RW),
    .COL_BITS_WIDTH(CW), .BEAT_WIDTH(BW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_lane_en(in_lane_en), .in_score(in_score), .in_row(in_row), .in_col(in_col),
    .threshold(threshold),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_score(res_score), .res_row(res_row), .res_col(res_col),
    .res_found(res_found), .res_above(res_above), .res_beats(res_beats)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: scan beats in arrival order and lanes in index order; a cell
  // replaces the current best only if strictly larger, so the earliest beat
  // and then the lowest lane win ties.
  task automatic model();
    e_found = 0; e_score = 0; e_row = 0; e_col = 0;
    for (int b = 0; b < nb; b++)
      for (int l = 0; l < L; l++)
        if (b_en[b][l] && (!e_found || b_score[b][l] > e_score)) begin
          e_found = 1;
          e_score = b_score[b][l];
          e_row   = b_row[b][l];
          e_col   = b_col[b][l];
        end
    e_above = e_found && (e_score >= cur_thr);
    e_beats = (nb > (1 << BW) - 1) ? (1 << BW) - 1 : nb;
  endtask

  task automatic set_lane(input int b, input int l, input int s, input bit en);
    b_score[b][l] = s;
    b_en[b][l]    = en;
    b_row[b][l]   = (b * 4 + l + 1) % 128;
    b_col[b][l]   = (b * 3 + l * 5 + 2) % 128;
  endtask

  task automatic rand_frame(input int n, input int smax);
    nb = n;
    for (int b = 0; b < n; b++)
      for (int l = 0; l < L; l++) begin
        b_score[b][l] = $urandom_range(0, smax);
        b_en[b][l]    = ($urandom_range(0, 3) != 0);
        b_row[b][l]   = $urandom_range(0, 127);
        b_col[b][l]   = $urandom_range(0, 127);
      end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  1);
    chk({tag, "_res_valid"}, 32'(res_valid), 0);
    chk({tag, "_res_score"}, 32'(res_score), 0);
    chk({tag, "_res_row"},   32'(res_row),   0);
    chk({tag, "_res_col"},   32'(res_col),   0);
    chk({tag, "_res_found"}, 32'(res_found), 0);
    chk({tag, "_res_above"}, 32'(res_above), 0);
    chk({tag, "_res_beats"}, 32'(res_beats), 0);
  endtask

  // Drive nb beats back to back; returns at the negedge after the last
  // acceptance edge.
  task automatic send_frame(input string tag);
    threshold = SW'(cur_thr);
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_last  = (b == nb - 1);
      for (int l = 0; l < L; l++) begin
        in_lane_en[l]        = b_en[b][l];
        in_score[l*SW +: SW] = SW'(b_score[b][l]);
        in_row[l*RW +: RW]   = RW'(b_row[b][l]);
        in_col[l*CW +: CW]   = CW'(b_col[b][l]);
      end
      if (b == 0) chk({tag, "_rdy_accum"}, 32'(in_ready), 1);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({tag, "_rdy_drain"}, 32'(in_ready), 0);
  endtask

  // Check latency (result valid right after the D+1-th edge), the result
  // fields, stability while held, and the handshake return to ACCUM.
  task automatic wait_result(input string tag, input int hold);
    model();
    for (int k = 1; k <= D + 1; k++) begin
      @(negedge clk);
      chk({tag, "_lat"}, 32'(res_valid), 32'(k == D + 1));
    end
    chk({tag, "_score"}, 32'(res_score), e_score);
    chk({tag, "_row"},   32'(res_row),   e_row);
    chk({tag, "_col"},   32'(res_col),   e_col);
    chk({tag, "_found"}, 32'(res_found), 32'(e_found));
    chk({tag, "_above"}, 32'(res_above), 32'(e_above));
    chk({tag, "_beats"}, 32'(res_beats), e_beats);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_vld"},   32'(res_valid), 1);
      chk({tag, "_hold_rdy"},   32'(in_ready),  0);
      chk({tag, "_hold_score"}, 32'(res_score), e_score);
      chk({tag, "_hold_row"},   32'(res_row),   e_row);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_hs_vld"}, 32'(res_valid), 0);
    chk({tag, "_hs_rdy"}, 32'(in_ready),  1);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_lane_en = '0; in_score = '0; in_row = '0; in_col = '0;
    threshold = '0; res_ready = 1'b0; cur_thr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;

    // One beat, duplicate peak 9 on lanes 1 and 3: lane 1 wins.
    nb = 1; cur_thr = 0;
    set_lane(0, 0, 5, 1); set_lane(0, 1, 9, 1); set_lane(0, 2, 3, 1); set_lane(0, 3, 9, 1);
    send_frame("one");
    wait_result("one", 0);
    chk("one_row_lane1", 32'(res_row), 2);

    // Peak 20 in beat 1 and again in beat 2: earliest beat kept.
    nb = 3; cur_thr = 0;
    set_lane(0, 0, 1, 1);  set_lane(0, 1, 2, 1);  set_lane(0, 2, 3, 1);  set_lane(0, 3, 4, 1);
    set_lane(1, 0, 7, 1);  set_lane(1, 1, 20, 1); set_lane(1, 2, 20, 1); set_lane(1, 3, 5, 1);
    set_lane(2, 0, 20, 1); set_lane(2, 1, 0, 1);  set_lane(2, 2, 20, 1); set_lane(2, 3, 19, 1);
    send_frame("tie");
    wait_result("tie", 0);

    // Masked 50 hidden, enabled max 12, threshold at and above the max.
    nb = 1; cur_thr = 12;
    set_lane(0, 0, 50, 0); set_lane(0, 1, 12, 1); set_lane(0, 2, 3, 1); set_lane(0, 3, 12, 1);
    send_frame("mask12");
    wait_result("mask12", 0);
    cur_thr = 13;
    send_frame("mask13");
    wait_result("mask13", 0);

    // Every lane masked in every beat.
    nb = 2; cur_thr = 0;
    for (int b = 0; b < 2; b++)
      for (int l = 0; l < L; l++) set_lane(b, l, 30 + l, 0);
    send_frame("empty");
    wait_result("empty", 0);

    // Consumer stalls for 10 cycles.
    rand_frame(3, 63); cur_thr = 20;
    send_frame("stall");
    wait_result("stall", 10);

    // clr in DRAIN: frame discarded, no result pulse.
    rand_frame(2, 63);
    send_frame("clr");
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_reset_values("clr");
    for (int k = 0; k < D + 3; k++) begin
      @(negedge clk);
      chk("clr_no_vld", 32'(res_valid), 0);
    end
    rand_frame(2, 63);
    send_frame("after_clr");
    wait_result("after_clr", 0);

    // Asynchronous reset in DRAIN.
    rand_frame(3, 63);
    send_frame("arst");
    rst_n = 1'b0;
    #1;
    check_reset_values("arst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < D + 3; k++) begin
      @(negedge clk);
      chk("arst_no_vld", 32'(res_valid), 0);
    end
    rand_frame(2, 63);
    send_frame("after_arst");
    wait_result("after_arst", 0);

    // Beat counter saturation at all-ones.
    rand_frame(20, 200); cur_thr = 100;
    send_frame("sat");
    wait_result("sat", 0);

    // Randomized frames with a narrow score range to provoke ties.
    for (int f = 0; f < 25; f++) begin
      rand_frame($urandom_range(1, 6), 31);
      cur_thr = $urandom_range(0, 40);
      send_frame("rnd");
      wait_result("rnd", $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
